// File: rtl/timer_intc_dev_if.sv
// CPU data-bus bundle seen by memory-mapped devices: address, load/store
// strobes and store data from the CPU, read data back to the CPU.
interface timer_intc_dev_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] memAddrBus;
    logic             weBus;
    logic             reBus;
    logic [DBITS-1:0] dataBusOut;
    logic [DBITS-1:0] dataBusIn;

    modport master (
        output memAddrBus,
        output weBus,
        output reBus,
        output dataBusOut,
        input  dataBusIn
    );

    modport slave (
        input  memAddrBus,
        input  weBus,
        input  reBus,
        input  dataBusOut,
        output dataBusIn
    );
endinterface

// File: rtl/timer_intc_dev.sv
// Interval timer with level interrupt. A prescaler produces a tick every
// DIV_TICKS clocks; each tick advances TCNT, which wraps at TLIM and raises
// the ready flag (or overrun when ready is still pending). The interrupt
// request is ready & ie, registered, and is held until software clears ready.
module timer_intc_dev #(
    parameter int unsigned      DBITS     = 32,
    parameter logic [DBITS-1:0] BASE_ADDR = 32'hF000_0020,
    parameter int unsigned      DIV_TICKS = 10000,
    parameter logic [DBITS-1:0] IDN_VALUE = 32'h1
) (
    input  logic             clk,
    input  logic             reset,
    timer_intc_dev_if.slave  bus,
    output logic             inta,
    output logic [DBITS-1:0] idn
);
    localparam int unsigned PW = (DIV_TICKS > 1) ? $clog2(DIV_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_TICKS - 1);

    localparam logic [1:0] OFF_TCNT = 2'd0;
    localparam logic [1:0] OFF_TLIM = 2'd1;
    localparam logic [1:0] OFF_TCTL = 2'd2;

    // Architectural state
    logic [PW-1:0]    presc;
    logic [DBITS-1:0] tcnt;
    logic [DBITS-1:0] tlim;
    logic             ready;
    logic             overrun;
    logic             ie;

    // Next-state values
    logic [PW-1:0]    prescNext;
    logic [DBITS-1:0] tcntNext;
    logic [DBITS-1:0] tlimNext;
    logic             readyNext;
    logic             overrunNext;
    logic             ieNext;

    // Decode and event qualifiers
    logic             sel;
    logic [1:0]       regOff;
    logic             wrCnt;
    logic             wrLim;
    logic             wrCtl;
    logic             tick;
    logic             tickEff;
    logic             limHit;
    logic             clrReady;
    logic             clrOverrun;
    logic [DBITS-1:0] ctlWord;
    logic [1:0]       unusedAddrBits;

    // Byte-lane bits of the address play no part in register selection.
    assign unusedAddrBits = bus.memAddrBus[1:0];

    assign regOff = bus.memAddrBus[3:2];
    assign sel    = (bus.memAddrBus[DBITS-1:4] == BASE_ADDR[DBITS-1:4]) &&
                    (regOff != 2'd3);

    assign wrCnt = bus.weBus && sel && (regOff == OFF_TCNT);
    assign wrLim = bus.weBus && sel && (regOff == OFF_TLIM);
    assign wrCtl = bus.weBus && sel && (regOff == OFF_TCTL);

    // Software may only clear the flags: a 0 in the flag bit clears it.
    assign clrReady   = wrCtl && !bus.dataBusOut[0];
    assign clrOverrun = wrCtl && !bus.dataBusOut[2];

    assign tick    = (presc == PRESC_LAST);
    // A TCNT or TLIM write in the same cycle swallows the tick entirely.
    assign tickEff = tick && !wrCnt && !wrLim;
    assign limHit  = tickEff && (tlim != '0) && (tcnt == tlim - DBITS'(1));

    // Next-state computation for counter, limit and control flags
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        prescNext   = tick ? '0 : presc + PW'(1);
        tcntNext    = tcnt;
        tlimNext    = tlim;
        readyNext   = ready;
        overrunNext = overrun;
        ieNext      = ie;

        if (wrLim) begin
            tlimNext  = bus.dataBusOut;
            tcntNext  = '0;
            prescNext = '0;
        end else if (wrCnt) begin
            tcntNext = bus.dataBusOut;
        end else if (limHit) begin
            tcntNext = '0;
        end else if (tickEff) begin
            tcntNext = tcnt + DBITS'(1);
        end

        if (wrCtl) begin
            ieNext = bus.dataBusOut[8];
        end

        // A limit hit beats a concurrent clear so the event is never lost;
        // overrun only marks a hit that lands on a still-pending ready.
        if (limHit) begin
            readyNext = 1'b1;
        end else if (clrReady) begin
            readyNext = 1'b0;
        end

        if (limHit && ready && !clrReady) begin
            overrunNext = 1'b1;
        end else if (clrOverrun) begin
            overrunNext = 1'b0;
        end
    end

    // State register, including the registered interrupt request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc   <= '0;
            tcnt    <= '0;
            tlim    <= '0;
            ready   <= 1'b0;
            overrun <= 1'b0;
            ie      <= 1'b0;
            inta    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values; inta must see the old ready/ie, not the new.
            presc   <= prescNext;
            tcnt    <= tcntNext;
            tlim    <= tlimNext;
            ready   <= readyNext;
            overrun <= overrunNext;
            ie      <= ieNext;
            inta    <= ready & ie;
        end
    end

    // Control register image: only ready, overrun and ie are implemented
    always_comb begin
        ctlWord    = '0;
        ctlWord[0] = ready;
        ctlWord[2] = overrun;
        ctlWord[8] = ie;
    end

    // Read mux; drives zero unless this device is being read so the CPU can OR-merge
    always_comb begin
        bus.dataBusIn = '0;
        if (bus.reBus && sel) begin
            case (regOff)
                OFF_TCNT: bus.dataBusIn = tcnt;
                OFF_TLIM: bus.dataBusIn = tlim;
                OFF_TCTL: bus.dataBusIn = ctlWord;
                default:  bus.dataBusIn = '0;
            endcase
        end
    end

    assign idn = inta ? IDN_VALUE : '0;
endmodule

// File: tb/tb_timer_intc_dev.sv
// Self-checking bench for timer_intc_dev with a 4-clock prescaler.
// Expected read data goes into a scoreboard queue when a read is driven and
// is popped when the combinational read data is sampled.
module tb_timer_intc_dev;
    localparam logic [31:0] BASE = 32'hF000_0020;
    localparam logic [31:0] A_TCNT = BASE + 32'h0;
    localparam logic [31:0] A_TLIM = BASE + 32'h4;
    localparam logic [31:0] A_TCTL = BASE + 32'h8;
    localparam logic [31:0] A_HOLE = BASE + 32'hC;
    localparam logic [31:0] IDN = 32'h1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic [31:0] expRead;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inta;
    logic [31:0] idn;

    int          passCount = 0;
    int          checkCount = 0;
    logic [31:0] sbQ[$];
    vec_t        vecs[16];

    timer_intc_dev_if #(.DBITS(32)) bus ();

    timer_intc_dev #(
        .DBITS    (32),
        .BASE_ADDR(BASE),
        .DIV_TICKS(4),
        .IDN_VALUE(IDN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .inta (inta),
        .idn  (idn)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    endtask

    task automatic idleBus();
        bus.memAddrBus = '0;
        bus.weBus      = 1'b0;
        bus.reBus      = 1'b0;
        bus.dataBusOut = '0;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; the store lands on the next rising edge
    // and the task returns at the following negedge.
    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
        bus.memAddrBus = addr;
        bus.dataBusOut = data;
        bus.weBus      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idleBus();
    endtask

    // Combinational read, completes 1 ns after being called with no clock edge.
    task automatic readReg(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.memAddrBus = addr;
        bus.reBus      = 1'b1;
        sbQ.push_back(exp);
        #1;
        check(name, bus.dataBusIn, sbQ.pop_front());
        bus.reBus = 1'b0;
    endtask

    task automatic checkIrq(input logic expInta, input string name);
        check({name, ".inta"}, {31'd0, inta}, {31'd0, expInta});
        check({name, ".idn"}, idn, expInta ? IDN : 32'h0);
    endtask

    initial begin
        // Decode/idle table; row i runs in the cycle after TLIM-write edge P+i,
        // so TCNT there equals i/4. Each row crosses exactly one rising edge.
        vecs[0]  = '{A_TCNT,            1'b0, 1'b1, 32'h0,        32'h0,      "tbl.tcnt0"};
        vecs[1]  = '{A_TLIM,            1'b0, 1'b1, 32'h0,        32'h1000,   "tbl.tlim"};
        vecs[2]  = '{A_TCTL,            1'b0, 1'b1, 32'h0,        32'h001,    "tbl.tctl"};
        vecs[3]  = '{A_HOLE,            1'b0, 1'b1, 32'h0,        32'h0,      "tbl.hole_rd"};
        vecs[4]  = '{BASE + 32'h10,     1'b0, 1'b1, 32'h0,        32'h0,      "tbl.next_blk"};
        vecs[5]  = '{A_TLIM,            1'b0, 1'b0, 32'h0,        32'h0,      "tbl.idle"};
        vecs[6]  = '{A_HOLE,            1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,     "tbl.hole_wr1"};
        vecs[7]  = '{A_HOLE,            1'b1, 1'b1, 32'h0,        32'h0,      "tbl.hole_wr0"};
        vecs[8]  = '{A_TCNT,            1'b0, 1'b1, 32'h0,        32'h2,      "tbl.tcnt_kept"};
        vecs[9]  = '{A_TLIM,            1'b0, 1'b1, 32'h0,        32'h1000,   "tbl.tlim_kept"};
        vecs[10] = '{A_TCTL,            1'b0, 1'b1, 32'h0,        32'h001,    "tbl.tctl_kept"};
        vecs[11] = '{BASE + 32'h5,      1'b0, 1'b1, 32'h0,        32'h1000,   "tbl.byte_bits"};
        vecs[12] = '{32'h7000_0024,     1'b0, 1'b1, 32'h0,        32'h0,      "tbl.hi_bit"};
        vecs[13] = '{A_TCTL,            1'b1, 1'b1, 32'h101,      32'h001,    "tbl.we_re"};
        vecs[14] = '{A_TCTL,            1'b0, 1'b1, 32'h0,        32'h101,    "tbl.ie_set"};
        vecs[15] = '{A_TCNT,            1'b0, 1'b1, 32'h0,        32'h3,      "tbl.tcnt3"};

        // Reset state, asserted from time zero
        idleBus();
        reset = 1'b0;
        #1;
        checkIrq(1'b0, "rst0");
        check("rst0.idle_bus", bus.dataBusIn, 32'h0);
        readReg(A_TCNT, 32'h0, "rst0.tcnt");
        readReg(A_TCTL, 32'h0, "rst0.tctl");
        @(negedge clk);
        reset = 1'b1;

        // Basic period and interrupt: TLIM write edge W, TCTL write on W+1
        writeReg(A_TLIM, 32'd3);
        writeReg(A_TCTL, 32'h100);
        waitClocks(10);                                  // after W+11
        readReg(A_TCTL, 32'h100, "s1.before_hit");
        waitClocks(1);                                   // after W+12
        readReg(A_TCTL, 32'h101, "s1.ready");
        checkIrq(1'b0, "s1.irq_lag");
        waitClocks(1);                                   // after W+13
        checkIrq(1'b1, "s1.irq");
        readReg(A_TCNT, 32'h0, "s1.tcnt_wrapped");

        // Acknowledge on W+14; the request drops one edge later
        writeReg(A_TCTL, 32'h100);
        checkIrq(1'b1, "s2.irq_hold");
        waitClocks(1);                                   // after W+15
        checkIrq(1'b0, "s2.irq_drop");
        readReg(A_TCTL, 32'h100, "s2.tctl");

        // Overrun with interrupts disabled: TLIM=2 written on edge L
        writeReg(A_TCTL, 32'h0);
        writeReg(A_TLIM, 32'd2);
        waitClocks(7);                                   // after L+7
        readReg(A_TCTL, 32'h000, "s3.before_hit");
        waitClocks(1);                                   // after L+8
        readReg(A_TCTL, 32'h001, "s3.first_hit");
        waitClocks(8);                                   // after L+16
        readReg(A_TCTL, 32'h005, "s3.second_hit");
        checkIrq(1'b0, "s3.no_irq");

        // TCNT write on tick edge L+20 wins over the tick
        waitClocks(3);                                   // after L+19
        writeReg(A_TCNT, 32'h55);
        readReg(A_TCNT, 32'h55, "s4.wr_beats_tick");
        waitClocks(4);                                   // after L+24
        readReg(A_TCNT, 32'h56, "s4.next_tick");

        // Clear ready on the limit-hit edge: set wins, overrun untouched
        writeReg(A_TCTL, 32'h001);                       // clear overrun only
        readReg(A_TCTL, 32'h001, "s4.ovr_cleared");
        writeReg(A_TLIM, 32'd2);                         // edge M
        waitClocks(7);                                   // after M+7
        writeReg(A_TCTL, 32'h000);                       // edge M+8 is the hit
        readReg(A_TCTL, 32'h001, "s4.set_beats_clear");

        // Decode and idle-bus table, starting after TLIM write edge P
        writeReg(A_TLIM, 32'h1000);
        for (int i = 0; i < 16; i++) begin
            bus.memAddrBus = vecs[i].addr;
            bus.weBus      = vecs[i].we;
            bus.reBus      = vecs[i].re;
            bus.dataBusOut = vecs[i].wdata;
            sbQ.push_back(vecs[i].expRead);
            #1;
            check(vecs[i].name, bus.dataBusIn, sbQ.pop_front());
            @(negedge clk);
        end
        idleBus();                                       // after P+16

        // Asynchronous reset mid-count with the request active
        writeReg(A_TCNT, 32'h7);                         // after P+17
        readReg(A_TCNT, 32'h7, "s6.tcnt_pre");
        checkIrq(1'b1, "s6.irq_pre");
        reset = 1'b0;
        #1;
        checkIrq(1'b0, "s6.irq_async");
        readReg(A_TCNT, 32'h0, "s6.tcnt_async");
        readReg(A_TLIM, 32'h0, "s6.tlim_async");
        readReg(A_TCTL, 32'h0, "s6.tctl_async");
        waitClocks(2);
        reset = 1'b1;                                    // released at negedge R

        // Prescaler restarts from zero: first tick is edge R+4
        waitClocks(3);                                   // after R+3
        readReg(A_TCNT, 32'h0, "s6.restart_pre");
        waitClocks(1);                                   // after R+4
        readReg(A_TCNT, 32'h1, "s6.restart_tick");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
